mem_arbiter_rv: RTL and testbench



---
 rtl/mem_arbiter_rv.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter_rv.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rv.sv
// mem_arbiter_rv: shares one single-ported memory between the fetch port and
// the data port. One transaction in flight at a time; data has priority, but
// after MAX_DGRANT consecutive contested data wins the fetch port is forced in.
module mem_arbiter_rv #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_DGRANT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = data port owns the transaction
  logic [CNT_W-1:0]    dcount_q, dcount_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                fetch_win;

  // State and memory-request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      dcount_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      dcount_q    <= dcount_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Arbitration, next-state and grant/rvalid strobes
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    dcount_d    = dcount_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if_rvalid   = 1'b0;
    d_rvalid    = 1'b0;
    fetch_win   = if_req && (!d_req || (dcount_q == CNT_W'(MAX_DGRANT)));

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d   = REQ;
          mem_req_d = 1'b1;
          if (fetch_win) begin
            owner_d     = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            dcount_d    = '0;
          end else begin
            owner_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (!if_req) begin
              dcount_d = '0;
            end else if (dcount_q != CNT_W'(MAX_DGRANT)) begin
              dcount_d = CNT_W'(dcount_q + CNT_W'(1));
            end
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if_gnt    = !owner_q;
          d_gnt     = owner_q;
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? IDLE : RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          if_rvalid = !owner_q;
          d_rvalid  = owner_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Read data passes through only in the owner's rvalid cycle
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter_rv.sv
// Bench for mem_arbiter_rv: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter_rv;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter_rv #(.ADDR_W(AW), .DATA_W(DW), .MAX_DGRANT(MAXD)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction, described by its fields
  bit          m_active;   // a transaction has been accepted by the arbiter
  bit          m_granted;  // memory has accepted it, waiting for read data
  bit          m_is_data;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  int          m_contested_dwins;

  // Snapshot of DUT outputs at the last sample point
  logic s_if_gnt, s_d_gnt, s_if_rvalid, s_d_rvalid, s_busy, s_mem_req, s_mem_we;
  logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Sample on the falling edge, compare with the model, advance the model
  task automatic step();
    bit fwin;
    @(negedge clk);
    s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_rvalid = if_rvalid; s_d_rvalid = d_rvalid;
    s_busy = busy; s_mem_req = mem_req; s_mem_we = mem_we;
    s_if_rdata = if_rdata; s_d_rdata = d_rdata; s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
    if (rst) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_gnts", {30'd0, if_gnt, d_gnt}, 0);
      chk("rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      m_active = 0; m_granted = 0; m_contested_dwins = 0;
    end else begin
      bit exp_req, exp_ifg, exp_dg, exp_ifv, exp_dv;
      exp_req = m_active && !m_granted;
      exp_ifg = exp_req && mem_gnt && !m_is_data;
      exp_dg  = exp_req && mem_gnt && m_is_data;
      exp_ifv = m_active && m_granted && mem_rvalid && !m_is_data;
      exp_dv  = m_active && m_granted && mem_rvalid && m_is_data;
      chk("busy", 32'(busy), 32'(m_active));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) begin
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("if_gnt", 32'(if_gnt), 32'(exp_ifg));
      chk("d_gnt", 32'(d_gnt), 32'(exp_dg));
      chk("if_rvalid", 32'(if_rvalid), 32'(exp_ifv));
      chk("d_rvalid", 32'(d_rvalid), 32'(exp_dv));
      chk("if_rdata", if_rdata, exp_ifv ? mem_rdata : 32'd0);
      chk("d_rdata", d_rdata, exp_dv ? mem_rdata : 32'd0);
      // what the next clock edge does to the transaction
      if (!m_active) begin
        if (if_req || d_req) begin
          fwin = if_req && (!d_req || m_contested_dwins >= int'(MAXD));
          m_active = 1; m_granted = 0; m_is_data = !fwin;
          m_we    = fwin ? 1'b0 : d_we;
          m_addr  = fwin ? if_addr : d_addr;
          m_wdata = d_wdata;
          if (fwin || !if_req) m_contested_dwins = 0;
          else if (m_contested_dwins < int'(MAXD)) m_contested_dwins++;
        end
      end else if (!m_granted) begin
        if (mem_gnt) begin
          if (m_we) m_active = 0;
          else m_granted = 1;
        end
      end else if (mem_rvalid) begin
        m_active = 0; m_granted = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_req = 0; d_req = 0; d_we = 0; mem_gnt = 0; mem_rvalid = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1; step();
    rst = 0;
  endtask

  string order;
  int    ngr;

  initial begin
    quiet();
    rst = 1;
    step();
    chk("reset_busy_lit", 32'(s_busy), 32'd0);
    rst = 0;

    // Single fetch
    if_req = 1; if_addr = 32'h100;
    step();                                   // t0
    mem_gnt = 1;
    step();                                   // t1
    chk("sf_mem_req_t1", 32'(s_mem_req), 32'd1);
    chk("sf_mem_addr_t1", s_mem_addr, 32'h100);
    chk("sf_if_gnt_t1", 32'(s_if_gnt), 32'd1);
    if_req = 0; mem_gnt = 0;
    step();                                   // t2
    chk("sf_mem_req_t2", 32'(s_mem_req), 32'd0);
    mem_rvalid = 1; mem_rdata = 32'h00500093;
    step();                                   // t3
    chk("sf_if_rvalid_t3", 32'(s_if_rvalid), 32'd1);
    chk("sf_if_rdata_t3", s_if_rdata, 32'h00500093);
    mem_rvalid = 0; mem_rdata = 0;
    step();                                   // t4
    chk("sf_busy_t4", 32'(s_busy), 32'd0);

    // Contention: data write first, fetch after one bubble
    do_reset();
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    mem_gnt = 1;
    step();
    step();
    chk("ct_d_gnt", 32'(s_d_gnt), 32'd1);
    chk("ct_mem_we", 32'(s_mem_we), 32'd1);
    chk("ct_mem_wdata", s_mem_wdata, 32'hDEADBEEF);
    chk("ct_mem_addr", s_mem_addr, 32'h2000);
    d_req = 0; d_we = 0;
    step();
    chk("ct_bubble_req", 32'(s_mem_req), 32'd0);
    step();
    chk("ct_if_mem_req", 32'(s_mem_req), 32'd1);
    chk("ct_if_addr", s_mem_addr, 32'h104);
    chk("ct_if_gnt", 32'(s_if_gnt), 32'd1);

    // Starvation bound: D D D D I D
    do_reset();
    if_req = 1; if_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h5000; mem_gnt = 1;
    order = ""; ngr = 0;
    for (int c = 0; c < 60 && ngr < 6; c++) begin
      step();
      mem_rvalid = s_if_gnt || s_d_gnt;
      mem_rdata  = 32'(c);
      if (s_d_gnt)  begin order = {order, "D"}; ngr++; end
      if (s_if_gnt) begin order = {order, "I"}; ngr++; end
    end
    chk("sv_grant_count", 32'(ngr), 32'd6);
    if (ngr == 6) begin
      for (int k = 0; k < 6; k++)
        chk($sformatf("sv_order_%0d", k), 32'(order[k]), (k == 4) ? 32'("I") : 32'("D"));
    end

    // Grant backpressure on a data read
    do_reset();
    d_req = 1; d_addr = 32'h3000; if_req = 1; if_addr = 32'h108;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_mem_req", 32'(s_mem_req), 32'd1);
      chk("bp_mem_addr", s_mem_addr, 32'h3000);
      chk("bp_mem_we", 32'(s_mem_we), 32'd0);
      chk("bp_gnts", {30'd0, s_if_gnt, s_d_gnt}, 32'd0);
    end
    mem_gnt = 1;
    step();
    chk("bp_d_gnt", 32'(s_d_gnt), 32'd1);

    // Reset while waiting for read data
    do_reset();
    if_req = 1; if_addr = 32'h180;
    step();
    mem_gnt = 1;
    step();
    if_req = 0; mem_gnt = 0;
    step();
    chk("rr_in_resp", 32'(s_busy), 32'd1);
    rst = 1;
    step();
    chk("rr_busy", 32'(s_busy), 32'd0);
    chk("rr_mem_req", 32'(s_mem_req), 32'd0);
    rst = 0;
    step();
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    step();
    chk("rr_no_rvalid", {30'd0, s_if_rvalid, s_d_rvalid}, 32'd0);
    chk("rr_if_rdata", s_if_rdata, 32'd0);
    mem_rvalid = 0;

    // Write completion returns straight to IDLE
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h60; d_wdata = 32'h55AA; mem_gnt = 1;
    step();
    step();
    chk("wc_d_gnt", 32'(s_d_gnt), 32'd1);
    d_req = 0; d_we = 0; if_req = 1; if_addr = 32'h200; mem_gnt = 0;
    step();
    chk("wc_idle", 32'(s_busy), 32'd0);
    step();
    chk("wc_mem_req", 32'(s_mem_req), 32'd1);
    chk("wc_mem_addr", s_mem_addr, 32'h200);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (!if_req || s_if_gnt) begin
        if_req  = ($urandom_range(0, 2) == 0);
        if_addr = $urandom;
      end
      if (!d_req || s_d_gnt) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      mem_gnt    = $urandom_range(0, 1) == 1;
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      rst        = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
